// File: rtl/vram_scan_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out owns one read slot per upscaled pixel and a
// small write FIFO retires game-logic pixel writes in the remaining clocks.
module vram_scan_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_LOG2  = 2,
    parameter int ADDR_W      = 15,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              active_video,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              wr_drop
);

    localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(FB_W * FB_H);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [11:0]       data;
    } wr_req_t;

    // Constant multiply by FB_W built from one shifted add per set bit (160 = 128 + 32).
    function automatic logic [ADDR_W-1:0] mul_fb_w(input logic [ADDR_W-1:0] row);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W[i]) acc = acc + (row << i);
        end
        return acc;
    endfunction

    // ------------------------------------------------------------------ slot decode
    logic              rd_slot;
    logic [ADDR_W-1:0] rd_addr;

    assign rd_slot = active_video && (x[SCALE_LOG2-1:0] == '0);
    assign rd_addr = mul_fb_w(ADDR_W'(y >> SCALE_LOG2)) + ADDR_W'(x >> SCALE_LOG2);

    // ------------------------------------------------------------------ write FIFO
    wr_req_t          fifo_q [WFIFO_DEPTH];
    wr_req_t          head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_en_q;
    logic             push;
    logic             pop;
    logic             head_in_range;

    assign wr_ready      = rdy_en_q && (cnt_q != CNT_W'(WFIFO_DEPTH));
    assign push          = wr_valid && wr_ready;
    assign pop           = !rd_slot && (cnt_q != '0);
    assign head          = fifo_q[rd_ptr_q];
    assign head_in_range = {1'b0, head.addr} < FB_LIMIT;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: FIFO storage carries no reset; the count alone decides what is valid, which keeps
    // the array as plain registers/RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------ RAM port
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [11:0]       mem_wdata_q, mem_wdata_d;
    logic              wr_drop_q, wr_drop_d;

    // NOTE: every signal gets its default before the branches, so no path leaves a latch.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_drop_d   = wr_drop_q;
        if (rd_slot) begin
            mem_addr_d = rd_addr;
        end else if (pop) begin
            if (head_in_range) begin
                mem_addr_d  = head.addr;
                mem_wdata_d = head.data;
                mem_we_d    = 1'b1;
            end else begin
                wr_drop_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_drop   = wr_drop_q;

    // ------------------------------------------------------------------ pixel / sync pipe
    // Stage 1 sees mem_addr, stage 2 sees mem_rdata, the output registers form stage 3.
    logic [1:0]  act_pipe_q;
    logic [1:0]  rd_pipe_q;
    logic [2:0]  hs_pipe_q;
    logic [2:0]  vs_pipe_q;
    logic [11:0] pix_q, pix_d;
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        pix_d = rd_pipe_q[1] ? mem_rdata : pix_q;
        rgb_d = act_pipe_q[1] ? pix_d : 12'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_pipe_q <= '0;
            rd_pipe_q  <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            pix_q      <= '0;
            rgb_q      <= '0;
        end else begin
            act_pipe_q <= {act_pipe_q[0], active_video};
            rd_pipe_q  <= {rd_pipe_q[0], rd_slot};
            hs_pipe_q  <= {hs_pipe_q[1:0], hsync_i};
            vs_pipe_q  <= {vs_pipe_q[1:0], vsync_i};
            pix_q      <= pix_d;
            rgb_q      <= rgb_d;
        end
    end

    assign red     = rgb_q[11:8];
    assign green   = rgb_q[7:4];
    assign blue    = rgb_q[3:0];
    assign hsync_o = hs_pipe_q[2];
    assign vsync_o = vs_pipe_q[2];

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Bench for vram_scan_arbiter: RAM model returns addr[11:0]; accepted writes are queued as
// expected RAM writes and a monitor pops/compares on every mem_we.
module tb_vram_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x, y;
    logic        active_video, hsync_i, vsync_i;
    logic        wr_valid, wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = 12'h000;
    logic [3:0]  red, green, blue;
    logic        hsync_o, vsync_o, wr_drop;

    typedef struct packed {
        logic [14:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  scan_run = 1'b0;

    vram_scan_arbiter dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active_video(active_video),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .red(red), .green(green),
        .blue(blue), .hsync_o(hsync_o), .vsync_o(vsync_o), .wr_drop(wr_drop)
    );

    always #20 clk = ~clk;

    // Synchronous-read RAM whose contents are mem[a] = a[11:0].
    always @(posedge clk) mem_rdata <= mem_addr[11:0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (scan_run) x = (x == 10'd639) ? 10'd0 : x + 10'd1;
    endtask

    task automatic push(input logic [14:0] a, input logic [11:0] d, input bit expect_write);
        bit ready_before;
        bit accepted;
        accepted = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int n = 0; n < 64 && !accepted; n++) begin
            ready_before = wr_ready;
            tick();
            accepted = ready_before;
        end
        check("push_accepted", accepted, 1);
        if (accepted && expect_write) exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every RAM write must match the oldest expected write and must never
    // follow a read-slot cycle.
    initial begin : monitor
        wr_t e;
        bit  rd_edge;
        forever begin
            @(posedge clk);
            rd_edge = active_video && (x[1:0] == 2'b00);
            #1;
            if (rst_n && mem_we) begin
                check("we_after_read_slot", rd_edge, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr, e.addr);
                    check("write_data", mem_wdata, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; x = '0; y = '0; active_video = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        repeat (3) tick();
        check("rst_rgb", {red, green, blue}, 12'h000);
        check("rst_hsync", hsync_o, 1);
        check("rst_vsync", vsync_o, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wr_drop", wr_drop, 0);
        check("rst_wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        check("ready_before_edge", wr_ready, 0);
        tick();
        check("ready_after_edge", wr_ready, 1);

        // Scan: x=0..7 active on row 0, inputs of the x=0 cycle are cycle t
        y = 10'd0; x = 10'd0; active_video = 1'b1; scan_run = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n == 8) active_video = 1'b0;
            if (n == 1) check("scan_addr_t1", mem_addr, 0);
            if (n == 5) check("scan_addr_t5", mem_addr, 1);
            if (n >= 3 && n <= 6) check("scan_rgb_px0", {red, green, blue}, 12'h000);
            if (n >= 7 && n <= 10) check("scan_rgb_px1", {red, green, blue}, 12'h001);
            if (n == 11) check("scan_rgb_blank", {red, green, blue}, 12'h000);
        end
        scan_run = 1'b0;

        // Address map
        active_video = 1'b1; y = 10'd4; x = 10'd8;
        tick();
        check("map_y4_x8", mem_addr, 162);
        y = 10'd479; x = 10'd636;
        tick();
        check("map_y479_x636", mem_addr, 19199);
        active_video = 1'b0;
        tick();
        check("addr_hold_idle", mem_addr, 19199);

        // Backpressure: 5 back-to-back writes during a running active line
        y = 10'd0; x = 10'd0; active_video = 1'b1; scan_run = 1'b1;
        for (int i = 0; i < 5; i++) push(15'(100 + i), 12'(12'h300 + i), 1'b1);
        wr_valid = 1'b0;
        wait_drain("bp_drain");
        active_video = 1'b0; scan_run = 1'b0;
        tick();

        // Full FIFO: drain stalled by a stuck read slot
        active_video = 1'b1; x = 10'd0; y = 10'd0;
        for (int i = 0; i < 4; i++) push(15'(200 + i), 12'(12'h500 + i), 1'b1);
        wr_valid = 1'b0;
        check("full_ready_low", wr_ready, 0);
        wr_valid = 1'b1; wr_addr = 15'd204; wr_data = 12'h504;
        repeat (3) begin
            tick();
            check("full_held", wr_ready, 0);
        end
        active_video = 1'b0;
        push(15'd204, 12'h504, 1'b1);
        wr_valid = 1'b0;
        wait_drain("full_drain");

        // Drop of an out-of-range write
        push(15'd19200, 12'hFFF, 1'b0);
        wr_valid = 1'b0;
        repeat (3) tick();
        check("drop_flag", wr_drop, 1);
        push(15'd5, 12'h0AB, 1'b1);
        wr_valid = 1'b0;
        wait_drain("drop_then_write");
        check("drop_sticky", wr_drop, 1);

        // Sync delay aligned with RGB blanking; fb pixel (2,1) -> addr 321 = 12'h141
        y = 10'd8; x = 10'd4; active_video = 1'b1;
        repeat (4) tick();
        check("sync_pre_rgb", {red, green, blue}, 12'h141);
        active_video = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
        tick();
        check("sync_t1_h", hsync_o, 1);
        check("sync_t1_rgb", {red, green, blue}, 12'h141);
        tick();
        check("sync_t2_h", hsync_o, 1);
        check("sync_t2_rgb", {red, green, blue}, 12'h141);
        tick();
        check("sync_t3_h", hsync_o, 0);
        check("sync_t3_v", vsync_o, 0);
        check("sync_t3_rgb", {red, green, blue}, 12'h000);
        hsync_i = 1'b1; vsync_i = 1'b1;
        repeat (3) tick();
        check("sync_restore_h", hsync_o, 1);

        // Reset mid-op with 3 queued writes held by a stalled read slot
        active_video = 1'b1; y = 10'd8; x = 10'd4; hsync_i = 1'b0;
        for (int i = 0; i < 3; i++) push(15'(300 + i), 12'(12'h700 + i), 1'b0);
        wr_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst_rgb", {red, green, blue}, 12'h141);
        check("pre_rst_hsync", hsync_o, 0);
        #5 rst_n = 1'b0;
        #1;
        check("midrst_rgb", {red, green, blue}, 12'h000);
        check("midrst_hsync", hsync_o, 1);
        check("midrst_mem_we", mem_we, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_wr_ready", wr_ready, 0);
        repeat (2) tick();
        active_video = 1'b0; hsync_i = 1'b1; rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            check("post_rst_no_we", mem_we, 0);
        end
        check("post_rst_wr_drop", wr_drop, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
